// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_adder                                               |
// | Description : Bit-serial N-bit ripple adder. Operands and carry-in are   |
// |               captured on a start pulse, then one bit per clock is       |
// |               summed (LSB first) through a single full-adder cell and a  |
// |               carry flop. The full sum and carry-out are presented as    |
// |               registered outputs together with a one-cycle done strobe.  |
// |                                                                          |
// | Ports       : clk   - system clock, rising edge                          |
// |               rst_n - asynchronous active-low reset                      |
// |               start - request, sampled only while idle                   |
// |               a, b  - WIDTH-bit operands, captured on accepted start     |
// |               cin   - carry-in, captured on accepted start               |
// |               busy  - high while bits are being processed                |
// |               done  - one-cycle strobe, sum/cout valid                   |
// |               sum   - registered (a+b+cin) mod 2^WIDTH                   |
// |               cout  - registered carry out of bit WIDTH-1                |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned c_cnt_w = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_ps;
   logic               r_c;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_s;
   logic               w_c_next;
   logic [WIDTH-1:0]   w_ps_next;

   // Single full-adder cell working on the current LSBs and the carry flop.
   assign w_s       = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
   assign w_c_next  = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
   // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_ps    <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_c     <= cin;
                  r_ps    <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               r_c    <= w_c_next;
               r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_ps   <= w_ps_next;
               r_cnt  <= r_cnt + 1'b1;
               // Last bit: publish the result on the same edge so that
               // partial sums never reach the outputs.
               if (r_cnt == c_last) begin
                  r_sum   <= w_ps_next;
                  r_cout  <= w_c_next;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_adder                                            |
// | Description : Self-checking directed bench for serial_adder (WIDTH=8).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int done_snap;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done strobes, sampled away from the active edge.
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full operation with start pulsed for exactly one cycle. Checks busy/done
   // timing every cycle, that the old result holds during RUN, and the result.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string tag);
      logic [7:0] prev_sum;
      prev_sum = sum;
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ta; b = ~tb; cin = ~tc;   // must not disturb the operation in flight
      chk({tag, "_busy_e0"}, busy, 1);
      chk({tag, "_done_e0"}, done, 0);
      for (int i = 1; i < WIDTH; i++) begin
         @(posedge clk); #1;
         chk({tag, "_busy_run"}, busy, 1);
         chk({tag, "_done_run"}, done, 0);
      end
      chk({tag, "_sum_hold"}, sum, prev_sum);
      @(posedge clk); #1;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      @(posedge clk); #1;
      chk({tag, "_done_clr"}, done, 0);
      chk({tag, "_sum_keep"}, sum, es);
   endtask

   initial begin
      logic [8:0] model;
      logic [7:0] ra, rb;
      logic       rc;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum",  sum,  0);
      chk("rst_cout", cout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);

      // Directed vectors, expected values hand-computed.
      do_op(8'd3,   8'd5,   1'b0, 8'd8,  1'b0, "v3p5");
      do_op(8'd255, 8'd1,   1'b0, 8'd0,  1'b1, "v255p1");
      do_op(8'd200, 8'd100, 1'b1, 8'd45, 1'b1, "v200p100c");
      do_op(8'd0,   8'd0,   1'b1, 8'd1,  1'b0, "v0p0c");
      do_op(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, "vmax");
      do_op(8'd170, 8'd85,  1'b0, 8'd255, 1'b0, "valt");

      // start held high; operands change during RUN; back-to-back acceptance.
      done_snap = done_cnt;
      @(negedge clk);
      a = 8'd10; b = 8'd20; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      chk("hold_busy_e0", busy, 1);
      a = 8'd99; b = 8'd99;
      repeat (WIDTH - 1) @(posedge clk);
      #1;
      chk("hold_done_early", done, 0);
      @(posedge clk); #1;
      chk("hold_done", done, 1);
      chk("hold_sum",  sum, 30);
      chk("hold_cout", cout, 0);
      @(posedge clk); #1;
      chk("hold_idle_done", done, 0);
      chk("hold_idle_busy", busy, 0);
      @(posedge clk); #1;               // E0 + WIDTH + 2: next start accepted
      chk("b2b_accept", busy, 1);
      a = 8'd1; b = 8'd2; cin = 1'b1;
      repeat (WIDTH) @(posedge clk);
      #1;
      chk("b2b_done", done, 1);
      chk("b2b_sum",  sum, 198);
      chk("b2b_cout", cout, 0);
      @(posedge clk); #1;
      chk("b2b_gap", busy, 0);
      @(posedge clk); #1;
      chk("b2b_accept2", busy, 1);
      start = 1'b0;
      repeat (WIDTH) @(posedge clk);
      #1;
      chk("b2b2_done", done, 1);
      chk("b2b2_sum",  sum, 4);
      chk("b2b2_cout", cout, 0);
      @(posedge clk); #1;
      chk("b2b_strobes", done_cnt - done_snap, 3);

      // Reset mid-operation, asserted asynchronously away from any edge.
      @(negedge clk);
      a = 8'd7; b = 8'd9; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_sum",  sum,  0);
      chk("mrst_cout", cout, 0);
      done_snap = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (WIDTH + 4) @(negedge clk);
      chk("mrst_no_done", done_cnt - done_snap, 0);
      chk("mrst_idle", busy, 0);
      do_op(8'd1, 8'd1, 1'b0, 8'd2, 1'b0, "post_rst");

      // Operands from $urandom, expectation from a 9-bit behavioural sum.
      for (int n = 0; n < 20; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         do_op(ra, rb, rc, model[7:0], model[8], "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
